// File: rtl/pkt_timestamp_insert.sv
// Inserts one timestamp module header per packet, just before the first payload word.
// Stale timestamp headers are dropped on the way through.
module pkt_timestamp_insert #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter logic [CTRL_WIDTH-1:0] TIMESTAMP_CTRL = 'hfe,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  enable,
  input  logic [63:0]           stamp_counter,
  output logic [31:0]           inserted_cnt
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  typedef enum logic {MODULE_HDRS, IN_PACKET} state_t;

  word_t                      wmem [DEPTH];
  logic [63:0]                tmem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] w_wp_q, w_rp_q, t_wp_q, t_rp_q;
  logic [CW-1:0]              w_cnt_q, w_cnt_d;
  logic                       in_rdy_q;
  logic                       wr_in_pkt_q, wr_seen_data_q;
  state_t                     state_q, state_d;
  logic                       ts_en_q, ts_en_d, started_q, started_d;
  logic                       out_wr_q, out_wr_d;
  logic [CTRL_WIDTH-1:0]      out_ctrl_q, out_ctrl_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [31:0]                cnt_q, cnt_d;
  logic                       push, is_head, w_pop, t_pop, w_empty, en_eff;
  word_t                      head;

  assign push    = in_wr & in_rdy_q;
  assign is_head = push & ~wr_in_pkt_q;
  assign w_empty = (w_cnt_q == '0);
  assign head    = wmem[w_rp_q];
  assign w_cnt_d = w_cnt_q + CW'(push) - CW'(w_pop);

  // Storage only; occupancy and pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (push)    wmem[w_wp_q] <= '{ctrl: in_ctrl, data: in_data};
    if (is_head) tmem[t_wp_q] <= stamp_counter;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_wp_q         <= '0;
      w_rp_q         <= '0;
      t_wp_q         <= '0;
      t_rp_q         <= '0;
      w_cnt_q        <= '0;
      in_rdy_q       <= 1'b1;
      wr_in_pkt_q    <= 1'b0;
      wr_seen_data_q <= 1'b0;
    end else begin
      w_cnt_q  <= w_cnt_d;
      in_rdy_q <= (w_cnt_d < CW'(DEPTH-1));
      if (push)    w_wp_q <= w_wp_q + 1'b1;
      if (w_pop)   w_rp_q <= w_rp_q + 1'b1;
      if (is_head) t_wp_q <= t_wp_q + 1'b1;
      if (t_pop)   t_rp_q <= t_rp_q + 1'b1;
      if (push) begin
        if (!wr_in_pkt_q) wr_in_pkt_q <= 1'b1;
        if (in_ctrl == '0) wr_seen_data_q <= 1'b1;
        else if (wr_seen_data_q) begin
          wr_seen_data_q <= 1'b0;
          wr_in_pkt_q    <= 1'b0;
        end
      end
    end
  end

  // enable is taken live until the packet's first read-side action, then held to EOP.
  always_comb begin
    state_d    = state_q;
    ts_en_d    = ts_en_q;
    started_d  = started_q;
    w_pop      = 1'b0;
    t_pop      = 1'b0;
    out_wr_d   = 1'b0;
    out_ctrl_d = out_ctrl_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    en_eff     = started_q ? ts_en_q : enable;
    if (!w_empty && out_rdy) begin
      case (state_q)
        MODULE_HDRS: begin
          started_d = 1'b1;
          ts_en_d   = en_eff;
          if (head.ctrl == TIMESTAMP_CTRL) begin
            w_pop = 1'b1;
          end else if (head.ctrl != '0) begin
            w_pop      = 1'b1;
            out_wr_d   = 1'b1;
            out_ctrl_d = head.ctrl;
            out_data_d = head.data;
          end else if (en_eff) begin
            out_wr_d   = 1'b1;
            out_ctrl_d = TIMESTAMP_CTRL;
            out_data_d = DATA_WIDTH'(tmem[t_rp_q]);
            t_pop      = 1'b1;
            cnt_d      = cnt_q + 32'd1;
            state_d    = IN_PACKET;
          end else begin
            w_pop      = 1'b1;
            t_pop      = 1'b1;
            out_wr_d   = 1'b1;
            out_ctrl_d = head.ctrl;
            out_data_d = head.data;
            state_d    = IN_PACKET;
          end
        end
        IN_PACKET: begin
          w_pop      = 1'b1;
          out_wr_d   = 1'b1;
          out_ctrl_d = head.ctrl;
          out_data_d = head.data;
          if (head.ctrl != '0) begin
            state_d   = MODULE_HDRS;
            started_d = 1'b0;
          end
        end
        default: state_d = MODULE_HDRS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MODULE_HDRS;
      ts_en_q    <= 1'b0;
      started_q  <= 1'b0;
      out_wr_q   <= 1'b0;
      out_ctrl_q <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ts_en_q    <= ts_en_d;
      started_q  <= started_d;
      out_wr_q   <= out_wr_d;
      out_ctrl_q <= out_ctrl_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_rdy       = in_rdy_q;
  assign out_wr       = out_wr_q;
  assign out_ctrl     = out_ctrl_q;
  assign out_data     = out_data_q;
  assign inserted_cnt = cnt_q;
endmodule

// File: tb/tb_pkt_timestamp_insert.sv
// Directed packet tables plus randomized packets checked against a packet-level model.
module tb_pkt_timestamp_insert;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        enable;
  logic [63:0] stamp_counter;
  logic [31:0] inserted_cnt;

  pkt_timestamp_insert dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable(enable), .stamp_counter(stamp_counter), .inserted_cnt(inserted_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [7:0]  ic;
    logic [63:0] id;
    bit          ev;
    logic [7:0]  ec;
    logic [63:0] ed;
  } vec_t;

  vec_t         tbl[$];
  logic [71:0]  got[$];
  logic [71:0]  expq[$];
  int           checks = 0;
  int           errors = 0;
  bit           rnd_rdy = 0;
  logic [31:0]  model_cnt = 0;
  logic [63:0]  stamp_ctr;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: records every written word and checks the out_rdy rule.
  initial begin
    logic r;
    forever begin
      @(posedge clk);
      r = out_rdy;
      #1;
      if (out_wr) begin
        check("rdy_rule", {71'd0, r}, 72'd1);
        got.push_back({out_ctrl, out_data});
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [63:0] d, input logic [63:0] st);
    int t = 0;
    while (!in_rdy && t < 300) begin
      in_wr = 1'b0;
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("in_rdy_timeout", 72'd0, 72'd1);
    in_ctrl = c; in_data = d; stamp_counter = st; in_wr = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic wait_got(input string name, input int n);
    int t = 0;
    while (got.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, "_count"}, 72'(got.size()), 72'(n));
  endtask

  function automatic vec_t v(bit iv, logic [7:0] ic, logic [63:0] id,
                             bit ev, logic [7:0] ec, logic [63:0] ed);
    vec_t r;
    r.iv = iv; r.ic = ic; r.id = id; r.ev = ev; r.ec = ec; r.ed = ed;
    return r;
  endfunction

  task automatic run_table(input string name, input logic [63:0] st, input logic [31:0] cnt_exp);
    int n = 0;
    int k = 0;
    got.delete();
    foreach (tbl[i]) if (tbl[i].iv) send(tbl[i].ic, tbl[i].id, st);
    foreach (tbl[i]) if (tbl[i].ev) n++;
    wait_got(name, n);
    foreach (tbl[i]) begin
      if (tbl[i].ev) begin
        check(name, (k < got.size()) ? got[k] : 72'hx, {tbl[i].ec, tbl[i].ed});
        k++;
      end
    end
    check({name, "_cnt"}, 72'(inserted_cnt), 72'(cnt_exp));
  endtask

  task automatic fill_test1();
    tbl.delete();
    tbl.push_back(v(1, 8'hff, 64'h00aa, 1, 8'hff, 64'h00aa));
    tbl.push_back(v(1, 8'h00, 64'hd1,   1, 8'hfe, 64'h1000));
    tbl.push_back(v(1, 8'h00, 64'hd2,   1, 8'h00, 64'hd1));
    tbl.push_back(v(1, 8'h00, 64'hd3,   1, 8'h00, 64'hd2));
    tbl.push_back(v(1, 8'h80, 64'he0,   1, 8'h00, 64'hd3));
    tbl.push_back(v(0, 8'h00, 64'h0,    1, 8'h80, 64'he0));
  endtask

  // Packet-level reference: drop stale stamp headers, add one after the headers if enabled.
  task automatic rand_packet(input bit en);
    logic [7:0]  hc[$];
    logic [63:0] hd[$];
    logic [63:0] head_stamp, d;
    logic [7:0]  c;
    int nh, nd;
    nh = $urandom_range(0, 2);
    nd = $urandom_range(1, 3);
    for (int i = 0; i < nh; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 8'hfe : 8'($urandom_range(1, 253));
      hc.push_back(c);
      hd.push_back({$urandom, $urandom});
    end
    for (int i = 0; i < nd; i++) begin
      hc.push_back(8'h00);
      hd.push_back({$urandom, $urandom});
    end
    hc.push_back(8'($urandom_range(1, 253)));
    hd.push_back({$urandom, $urandom});
    head_stamp = stamp_ctr;
    for (int i = 0; i < nh; i++) if (hc[i] != 8'hfe) expq.push_back({hc[i], hd[i]});
    if (en) begin
      expq.push_back({8'hfe, head_stamp});
      model_cnt++;
    end
    for (int i = nh; i < hc.size(); i++) expq.push_back({hc[i], hd[i]});
    foreach (hc[i]) begin
      d = hd[i];
      send(hc[i], d, stamp_ctr);
      stamp_ctr = stamp_ctr + 64'($urandom_range(1, 5));
    end
  endtask

  initial begin
    logic [71:0] exp4[6];
    reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1;
    enable = 1'b1; stamp_counter = '0;
    repeat (3) @(negedge clk);
    check("rst_out_wr",   72'(out_wr),       72'd0);
    check("rst_out_data", 72'(out_data),     72'd0);
    check("rst_out_ctrl", 72'(out_ctrl),     72'd0);
    check("rst_cnt",      72'(inserted_cnt), 72'd0);
    check("rst_in_rdy",   72'(in_rdy),       72'd1);
    reset = 1'b0;
    @(negedge clk);

    fill_test1();
    run_table("t1_basic", 64'h1000, 32'd1);

    tbl.delete();
    tbl.push_back(v(1, 8'hff, 64'h0bb, 1, 8'hff, 64'h0bb));
    tbl.push_back(v(1, 8'hfe, 64'hdead, 1, 8'hfe, 64'h2000));
    tbl.push_back(v(1, 8'h00, 64'hc1,  1, 8'h00, 64'hc1));
    tbl.push_back(v(1, 8'h00, 64'hc2,  1, 8'h00, 64'hc2));
    tbl.push_back(v(1, 8'h80, 64'hc3,  1, 8'h80, 64'hc3));
    run_table("t2_restamp", 64'h2000, 32'd2);

    enable = 1'b0;
    tbl.delete();
    tbl.push_back(v(1, 8'hff, 64'h0cc, 1, 8'hff, 64'h0cc));
    tbl.push_back(v(1, 8'hfe, 64'hdead, 1, 8'h00, 64'hb1));
    tbl.push_back(v(1, 8'h00, 64'hb1,  1, 8'h40, 64'hb2));
    tbl.push_back(v(1, 8'h40, 64'hb2,  0, 8'h00, 64'h0));
    run_table("t3_disabled", 64'h3000, 32'd2);
    enable = 1'b1;

    // Back-to-back 2-word packets with a 5-cycle downstream stall.
    got.delete();
    fork
      begin
        send(8'h00, 64'ha1, 64'd100);
        send(8'h80, 64'ha2, 64'd101);
        send(8'h00, 64'hb1, 64'd108);
        send(8'h80, 64'hb2, 64'd109);
      end
      begin
        repeat (3) @(negedge clk);
        out_rdy = 1'b0;
        repeat (5) @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    exp4 = '{{8'hfe, 64'd100}, {8'h00, 64'ha1}, {8'h80, 64'ha2},
             {8'hfe, 64'd108}, {8'h00, 64'hb1}, {8'h80, 64'hb2}};
    wait_got("t4_stall", 6);
    for (int i = 0; i < 6; i++) check("t4_stall", (i < got.size()) ? got[i] : 72'hx, exp4[i]);
    check("t4_cnt", 72'(inserted_cnt), 72'd4);

    // Randomized packets; enable only changes while the pipe is drained.
    model_cnt = inserted_cnt;
    stamp_ctr = 64'hffff_ffff_ffff_fff0;
    rnd_rdy = 1'b1;
    fork
      while (rnd_rdy) begin
        @(negedge clk);
        out_rdy = $urandom_range(0, 1);
      end
    join_none
    for (int b = 0; b < 10; b++) begin
      got.delete();
      expq.delete();
      enable = (b % 3 != 2);
      for (int p = 0; p < 100; p++) rand_packet(enable);
      wait_got("t5_rand", expq.size());
      for (int i = 0; i < expq.size(); i++) begin
        if (i >= got.size()) break;
        check("t5_rand", got[i], expq[i]);
      end
      check("t5_cnt", 72'(inserted_cnt), 72'(model_cnt));
    end
    rnd_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_rdy = 1'b1;

    // Reset while a packet is being written and read.
    enable = 1'b1;
    send(8'hff, 64'h11, 64'h55);
    send(8'h00, 64'h22, 64'h56);
    send(8'h00, 64'h33, 64'h57);
    reset = 1'b1;
    @(negedge clk);
    check("t6_out_wr",  72'(out_wr),       72'd0);
    check("t6_cnt",     72'(inserted_cnt), 72'd0);
    check("t6_in_rdy",  72'(in_rdy),       72'd1);
    reset = 1'b0;
    @(negedge clk);
    fill_test1();
    run_table("t6_after", 64'h1000, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
